// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: access sizes, FSM
// states and the byte-lane / legality helpers used by the datapath.
package rv32_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] addr);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << addr;
         SZ_H:    be = 4'b0011 << addr;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // True for any request that must be answered with an error instead of
   // being issued: misaligned halves/words, the reserved size, and the
   // unsigned flag on word loads or on any store.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr,
                                           input logic uns, input logic we);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr[0];
         SZ_W:    bad = (addr != 2'b00);
         default: bad = 1'b1;
      endcase
      if (uns && ((size == SZ_W) || we)) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane steering: replicates store data across the byte lanes
// and extracts/extends load data from the RAM read word.
module rv32_lsu_align
   import rv32_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane,
   input  logic [31:0] st_data,
   output logic [31:0] st_lanes,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // Replicate the store operand so every lane the byte enables select sees it.
   always_comb begin
      case (size)
         SZ_B:    st_lanes = {4{st_data[7:0]}};
         SZ_H:    st_lanes = {2{st_data[15:0]}};
         default: st_lanes = st_data;
      endcase
   end

   // Move the addressed lane to bit 0, then sign- or zero-extend to 32 bits.
   always_comb begin
      shifted = ld_word >> {lane, 3'b000};
      case (size)
         SZ_B:    ld_data = uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    ld_data = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/rv32_lsu.sv
// Load/store unit: takes one request at a time, issues a single RAM access,
// waits out the RAM read latency and returns a one-cycle response.
module rv32_lsu
   import rv32_lsu_pkg::*;
#(
   parameter int MEM_AW = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int CW = $clog2(RD_LAT + 1);

   lsu_state_e        state;
   lsu_state_e        state_nxt;
   logic              alive;
   logic              we_q;
   logic              uns_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [MEM_AW+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [4:0]        rd_q;
   logic [31:0]       rdata_q;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              req_bad;
   logic              cnt_zero;
   logic [31:0]       st_lanes;
   logic [31:0]       ld_data;
   logic              unused_addr_hi;

   assign accept         = req_valid & req_ready;
   assign req_bad        = lsu_misaligned(req_size, req_addr[1:0], req_unsigned, req_we);
   assign cnt_zero       = (cnt == '0);
   assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

   rv32_lsu_align u_align (
      .size     (size_q),
      .uns      (uns_q),
      .lane     (addr_q[1:0]),
      .st_data  (wdata_q),
      .st_lanes (st_lanes),
      .ld_word  (mem_rdata),
      .ld_data  (ld_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Keeps req_ready low until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive <= 1'b0;
      end else begin
         alive <= 1'b1;
      end
   end

   // Next-state and output decode; outputs are zero outside their state.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_rd    = '0;
      rsp_err   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            req_ready = alive;
            if (accept) begin
               state_nxt = req_bad ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q[MEM_AW+1:2];
            mem_be    = lsu_be(size_q, addr_q[1:0]);
            mem_wdata = we_q ? st_lanes : '0;
            state_nxt = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt_zero) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_rd    = rd_q;
            rsp_err   = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are latched on accept; load data is captured when the
   // read latency has elapsed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         uns_q   <= req_unsigned;
         err_q   <= req_bad;
         size_q  <= req_size;
         addr_q  <= req_addr[MEM_AW+1:0];
         wdata_q <= req_wdata;
         rd_q    <= req_rd;
         rdata_q <= '0;
      end else if ((state == WAIT) && cnt_zero) begin
         rdata_q <= ld_data;
      end
   end

   // Read-latency counter: loaded at issue, counts down while waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if ((state == ISSUE) && !we_q) begin
         cnt <= CW'(RD_LAT - 1);
      end else if ((state == WAIT) && !cnt_zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule
